fft_port_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter that shares one N-bit datapath between four requesters (e.g. FFT input buffer, twiddle ROM, bit-reverse reorder, debug injector).
- Drives the 2-bit select of the shared 4:1 word mux.
- Registers the granted word toward the downstream butterfly stage behind a valid/ready handshake.

---
 rtl/fft_port_arbiter_if.sv | 28 ++
 rtl/fft_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_fft_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_port_arbiter_if.sv
// Handshake bundle between the four requesters, the arbiter and the downstream butterfly stage.
// master = requester/downstream side, slave = arbiter side.
`timescale 1ns/1ps
interface fft_port_arbiter_if #(
  parameter int N = 16
);
  logic [3:0]     in_valid;
  logic [3:0]     in_last;
  logic [4*N-1:0] in_data;
  logic [3:0]     in_ready;
  logic [1:0]     sel;
  logic           busy;
  logic           out_valid;
  logic [N-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_src;
  logic           out_ready;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, sel, busy, out_valid, out_data, out_last, out_src
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, sel, busy, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/fft_port_arbiter.sv
// Round-robin packet-locked arbiter sharing one N-bit datapath between four requesters.
// Optional per-requester grant counters: define FFT_ARB_GRANT_CNT_EN.
`timescale 1ns/1ps
module fft_port_arbiter #(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_port_arbiter_if.slave    bus
`ifdef FFT_ARB_GRANT_CNT_EN
  ,
  output logic [4*CNT_W-1:0]   grant_cnt
`endif
);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  if (N < 1 || CNT_W < 1) begin : g_bad_param
    $error("fft_port_arbiter: N and CNT_W must be positive");
  end

  state_t       state_q, state_d;
  logic [1:0]   sel_q, sel_d;
  logic [1:0]   ptr_q, ptr_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic         out_last_q, out_last_d;
  logic [1:0]   out_src_q, out_src_d;

  logic [1:0]   gnt_idx;
  logic         any_req;
  logic         owner_rdy;
  logic         xfer;
  logic [3:0]   in_ready_w;
  logic [N-1:0] owner_data;

  // Scan from the farthest candidate back to ptr+1 so the nearest requester wins.
  always_comb begin
    gnt_idx = ptr_q;
    for (int i = 4; i >= 1; i--) begin
      if (bus.in_valid[ptr_q + 2'(i)]) gnt_idx = ptr_q + 2'(i);
    end
  end

  assign any_req    = |bus.in_valid;
  assign owner_rdy  = (state_q == S_LOCK) && (!out_valid_q || bus.out_ready);
  assign in_ready_w = owner_rdy ? (4'b0001 << sel_q) : 4'b0000;
  assign xfer       = owner_rdy && bus.in_valid[sel_q];
  assign owner_data = bus.in_data[sel_q*N +: N];

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          sel_d   = gnt_idx;
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        if (xfer && bus.in_last[sel_q]) begin
          state_d = S_IDLE;
          ptr_d   = sel_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A drain and a new word in the same cycle keep the register full.
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = owner_data;
      out_last_d  = bus.in_last[sel_q];
      out_src_d   = sel_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= 2'd0;
      ptr_q       <= 2'd3;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q == S_LOCK);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;

`ifdef FFT_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic             grant;

  assign grant = (state_q == S_IDLE) && any_req;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (grant && (gnt_idx == 2'(k))) cnt_d[k] = cnt_q[k] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_fft_port_arbiter.sv
// Bench for fft_port_arbiter: cycle table for arbitration/handshake plus scoreboarded packet scenarios.
`timescale 1ns/1ps
module tb_fft_port_arbiter;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_port_arbiter_if #(.N(N)) ifc ();

`ifdef FFT_ARB_GRANT_CNT_EN
  logic [63:0] grant_cnt;
`endif

  fft_port_arbiter #(.N(N), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
`ifdef FFT_ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit sb_en  = 1'b0;
  logic [18:0] sb_q [$];

  typedef struct {
    logic [3:0]  iv;
    logic [3:0]  il;
    logic [63:0] d;
    logic        ordy;
    logic [1:0]  sel;
    logic        busy;
    logic [3:0]  ird;
    logic        ov;
    logic [15:0] od;
    logic        ol;
    logic [1:0]  os;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Output-side scoreboard: compares each accepted beat against the oldest expected word.
  always @(negedge clk) begin
    if (sb_en && rst_n && ifc.out_valid && ifc.out_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: unexpected beat data=%0h src=%0d, expected none",
                 ifc.out_data, ifc.out_src);
      end else begin
        chk("sb_beat", {45'd0, ifc.out_data, ifc.out_last, ifc.out_src}, {45'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [15:0] d, input logic l, input logic [1:0] s);
    sb_q.push_back({d, l, s});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.in_valid  = 4'b0;
    ifc.in_last   = 4'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic xfer_word(input int k, input logic [15:0] d, input logic l);
    int  n = 0;
    bit  done = 1'b0;
    ifc.in_valid[k]         = 1'b1;
    ifc.in_data[k*N +: N]   = d;
    ifc.in_last[k]          = l;
    while (!done) begin
      @(negedge clk);
      if (ifc.in_ready[k]) done = 1'b1;
      else if (++n > 60) begin
        n_chk++;
        n_fail++;
        $display("FAIL handshake_timeout req%0d: in_ready stayed 0, expected 1", k);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int k, input logic [15:0] base, input int len);
    for (int w = 0; w < len; w++) xfer_word(k, base + 16'(w), (w == len - 1));
    ifc.in_valid[k] = 1'b0;
    ifc.in_last[k]  = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk(nm, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    tbl[0] = '{4'b0001, 4'b0001, {48'h0, 16'h1111}, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0, 16'h0000, 1'b0, 2'd0};
    tbl[1] = '{4'b0001, 4'b0001, {48'h0, 16'h1111}, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1, 16'h1111, 1'b1, 2'd0};
    tbl[2] = '{4'b0000, 4'b0000, 64'h0,             1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0};
    tbl[3] = '{4'b0001, 4'b0000, {48'h0, 16'h2222}, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0, 16'h0000, 1'b0, 2'd0};
    tbl[4] = '{4'b0001, 4'b0000, {48'h0, 16'h2222}, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b1, 16'h2222, 1'b0, 2'd0};
    tbl[5] = '{4'b0001, 4'b0001, {48'h0, 16'h2223}, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b1, 16'h2222, 1'b0, 2'd0};
    tbl[6] = '{4'b0001, 4'b0001, {48'h0, 16'h2223}, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1, 16'h2223, 1'b1, 2'd0};
    tbl[7] = '{4'b0010, 4'b0010, {32'h0, 16'h3333, 16'h0}, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 16'h0000, 1'b0, 2'd0};
    tbl[8] = '{4'b0110, 4'b0110, {16'h0, 16'h4444, 16'h3333, 16'h0}, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b1, 16'h3333, 1'b1, 2'd1};
    tbl[9] = '{4'b0100, 4'b0100, {16'h0, 16'h4444, 32'h0}, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 16'h0000, 1'b0, 2'd0};

    // Reset state
    rst_n = 1'b0;
    ifc.in_valid = 4'b0; ifc.in_last = 4'b0; ifc.in_data = '0; ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_out_data",  64'(ifc.out_data),  64'd0);
    chk("rst_out_last",  64'(ifc.out_last),  64'd0);
    chk("rst_out_src",   64'(ifc.out_src),   64'd0);
    chk("rst_sel",       64'(ifc.sel),       64'd0);
    chk("rst_busy",      64'(ifc.busy),      64'd0);
    chk("rst_in_ready",  64'(ifc.in_ready),  64'd0);
`ifdef FFT_ARB_GRANT_CNT_EN
    chk("rst_grant_cnt", grant_cnt, 64'd0);
`endif
    rst_n = 1'b1;

    // Cycle table
    for (int i = 0; i < 10; i++) begin
      ifc.in_valid  = tbl[i].iv;
      ifc.in_last   = tbl[i].il;
      ifc.in_data   = tbl[i].d;
      ifc.out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_sel", i),       64'(ifc.sel),       64'(tbl[i].sel));
      chk($sformatf("r%0d_busy", i),      64'(ifc.busy),      64'(tbl[i].busy));
      chk($sformatf("r%0d_in_ready", i),  64'(ifc.in_ready),  64'(tbl[i].ird));
      chk($sformatf("r%0d_out_valid", i), 64'(ifc.out_valid), 64'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("r%0d_out_data", i), 64'(ifc.out_data), 64'(tbl[i].od));
        chk($sformatf("r%0d_out_last", i), 64'(ifc.out_last), 64'(tbl[i].ol));
        chk($sformatf("r%0d_out_src", i),  64'(ifc.out_src),  64'(tbl[i].os));
      end
    end
`ifdef FFT_ARB_GRANT_CNT_EN
    chk("tbl_grant_cnt", grant_cnt, {16'd0, 16'd1, 16'd1, 16'd2});
`endif
    ifc.in_valid = 4'b0;
    ifc.in_last  = 4'b0;

    sb_en = 1'b1;

    // Round robin over four single-word requesters
    do_reset();
    push_exp(16'h5000, 1'b1, 2'd0);
    push_exp(16'h5001, 1'b1, 2'd1);
    push_exp(16'h5002, 1'b1, 2'd2);
    push_exp(16'h5003, 1'b1, 2'd3);
    push_exp(16'h5010, 1'b1, 2'd0);
    fork
      begin send_pkt(0, 16'h5000, 1); send_pkt(0, 16'h5010, 1); end
      send_pkt(1, 16'h5001, 1);
      send_pkt(2, 16'h5002, 1);
      send_pkt(3, 16'h5003, 1);
    join
    drain("rr_empty");

    // Locked 3-word packet from requester 2 while requester 1 waits
    do_reset();
    push_exp(16'hA000, 1'b0, 2'd2);
    push_exp(16'hA001, 1'b0, 2'd2);
    push_exp(16'hA002, 1'b1, 2'd2);
    push_exp(16'hB000, 1'b1, 2'd1);
    fork
      send_pkt(2, 16'hA000, 3);
      begin @(posedge clk); #1; send_pkt(1, 16'hB000, 1); end
      begin
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk($sformatf("lock_in_ready_c%0d", c), 64'(ifc.in_ready), 64'(4'b0100));
        end
      end
    join
    drain("lock_empty");

    // Owner stalls mid-packet while requester 3 waits
    do_reset();
    push_exp(16'hC000, 1'b0, 2'd0);
    push_exp(16'hC001, 1'b0, 2'd0);
    push_exp(16'hC002, 1'b0, 2'd0);
    push_exp(16'hC003, 1'b1, 2'd0);
    push_exp(16'hD000, 1'b1, 2'd3);
    xfer_word(0, 16'hC000, 1'b0);
    xfer_word(0, 16'hC001, 1'b0);
    ifc.in_valid[0] = 1'b0;
    ifc.in_valid[3] = 1'b1;
    ifc.in_data[3*N +: N] = 16'hD000;
    ifc.in_last[3] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("gap_busy_c%0d", c), 64'(ifc.busy), 64'd1);
      chk($sformatf("gap_sel_c%0d", c),  64'(ifc.sel),  64'd0);
      chk($sformatf("gap_rdy3_c%0d", c), 64'(ifc.in_ready[3]), 64'd0);
      if (c > 0) chk($sformatf("gap_out_valid_c%0d", c), 64'(ifc.out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    xfer_word(0, 16'hC002, 1'b0);
    xfer_word(0, 16'hC003, 1'b1);
    ifc.in_valid[0] = 1'b0;
    ifc.in_last[0]  = 1'b0;
    send_pkt(3, 16'hD000, 1);
    drain("gap_empty");

    // Backpressure: hold the output for 4 cycles, then drain at full rate
    do_reset();
    for (int w = 0; w < 6; w++) push_exp(16'hE000 + 16'(w), (w == 5), 2'd1);
    fork
      send_pkt(1, 16'hE000, 6);
      begin
        int n = 0;
        int cyc = 0;
        while (!ifc.out_valid && n < 20) begin
          @(posedge clk);
          #1 n++;
        end
        ifc.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk($sformatf("bp_out_data_c%0d", c), 64'(ifc.out_data),  64'(16'hE000));
          chk($sformatf("bp_out_valid_c%0d", c), 64'(ifc.out_valid), 64'd1);
          chk($sformatf("bp_in_ready_c%0d", c), 64'(ifc.in_ready),  64'd0);
          @(posedge clk);
          #1;
        end
        ifc.out_ready = 1'b1;
        while (sb_q.size() != 0 && cyc < 30) begin
          @(posedge clk);
          #1 cyc++;
        end
        chk("bp_drain_cycles", 64'(cyc), 64'd6);
      end
    join
    drain("bp_empty");

    // Reset mid-packet, then requester 3 alone is granted
    do_reset();
    push_exp(16'hF000, 1'b0, 2'd2);
    xfer_word(2, 16'hF000, 1'b0);
    xfer_word(2, 16'hF001, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("mid_rst_out_data",  64'(ifc.out_data),  64'd0);
    chk("mid_rst_out_last",  64'(ifc.out_last),  64'd0);
    chk("mid_rst_out_src",   64'(ifc.out_src),   64'd0);
    chk("mid_rst_sel",       64'(ifc.sel),       64'd0);
    chk("mid_rst_busy",      64'(ifc.busy),      64'd0);
    chk("mid_rst_in_ready",  64'(ifc.in_ready),  64'd0);
`ifdef FFT_ARB_GRANT_CNT_EN
    chk("mid_rst_grant_cnt", grant_cnt, 64'd0);
`endif
    chk("mid_rst_sb_empty", 64'(sb_q.size()), 64'd0);
    ifc.in_valid = 4'b0;
    ifc.in_last  = 4'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(16'h9000, 1'b1, 2'd3);
    fork
      send_pkt(3, 16'h9000, 1);
      begin
        @(posedge clk);
        #1;
        chk("post_rst_sel",  64'(ifc.sel),  64'd3);
        chk("post_rst_busy", 64'(ifc.busy), 64'd1);
      end
    join
    drain("post_rst_empty");
`ifdef FFT_ARB_GRANT_CNT_EN
    chk("post_rst_grant_cnt", grant_cnt, {16'd1, 48'd0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
